// File: rtl/sobel_frame_ctrl_if.sv
// Upstream raster-pixel stream into sobel_frame_ctrl: valid/ready handshake with a 24-bit {R,G,B} payload.
interface sobel_frame_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer ahead of sobel_top: lines with horizontal blanking, zero-pad flush, done pulse.
// Optional stall statistics output enabled by macro SOBEL_CTRL_STATS_EN.
module sobel_frame_ctrl #(
  parameter int unsigned IMG_W     = 640,
  parameter int unsigned IMG_H     = 480,
  parameter int unsigned HBLANK    = 4,
  parameter int unsigned FLUSH_CYC = 642
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  sobel_frame_ctrl_if.slave          pix,
  output logic                       rgb_enable,
  output logic [23:0]                rgb_data_out,
  output logic                       line_start,
  output logic                       busy,
  output logic                       frame_done,
  output logic [$clog2(IMG_H)-1:0]   row,
  output logic [$clog2(IMG_W)-1:0]   col
`ifdef SOBEL_CTRL_STATS_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned HW = $clog2(HBLANK + 1);
  localparam int unsigned FW = $clog2(FLUSH_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACTIVE, ST_HBLANK, ST_FLUSH, ST_DONE
  } state_t;

  state_t        state, state_d;
  logic [RW-1:0] row_d;
  logic [CW-1:0] col_d;
  logic [HW-1:0] hb_cnt, hb_cnt_d;
  logic [FW-1:0] fl_cnt, fl_cnt_d;
  logic          en_d, ls_d;
  logic [23:0]   data_d;
  logic          accept;

  // Ready depends on state only, so there is no path from s_valid back to s_ready.
  assign pix.s_ready = (state == ST_ACTIVE);
  assign accept      = pix.s_valid && (state == ST_ACTIVE);

  always_comb begin
    state_d  = state;
    row_d    = row;
    col_d    = col;
    hb_cnt_d = hb_cnt;
    fl_cnt_d = fl_cnt;
    en_d     = 1'b0;
    ls_d     = 1'b0;
    data_d   = 24'h000000;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ACTIVE;
          row_d    = '0;
          col_d    = '0;
          hb_cnt_d = '0;
          fl_cnt_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (accept) begin
          en_d   = 1'b1;
          data_d = pix.s_data;
          ls_d   = (col == '0);
          if (col == CW'(IMG_W - 1)) begin
            col_d = '0;
            if (row < RW'(IMG_H - 1)) begin
              row_d   = row + RW'(1);
              state_d = ST_HBLANK;
            end else begin
              state_d = ST_FLUSH;
            end
          end else begin
            col_d = col + CW'(1);
          end
        end
      end
      ST_HBLANK: begin
        if (hb_cnt == HW'(HBLANK - 1)) begin
          hb_cnt_d = '0;
          state_d  = ST_ACTIVE;
        end else begin
          hb_cnt_d = hb_cnt + HW'(1);
        end
      end
      ST_FLUSH: begin
        en_d = 1'b1;
        if (fl_cnt == FW'(FLUSH_CYC - 1)) begin
          fl_cnt_d = '0;
          state_d  = ST_DONE;
        end else begin
          fl_cnt_d = fl_cnt + FW'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Abort overrides every transition and squashes any output beat.
    if (abort) begin
      state_d  = ST_IDLE;
      row_d    = '0;
      col_d    = '0;
      hb_cnt_d = '0;
      fl_cnt_d = '0;
      en_d     = 1'b0;
      ls_d     = 1'b0;
      data_d   = 24'h000000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      row          <= '0;
      col          <= '0;
      hb_cnt       <= '0;
      fl_cnt       <= '0;
      rgb_enable   <= 1'b0;
      rgb_data_out <= 24'h000000;
      line_start   <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_d;
      row          <= row_d;
      col          <= col_d;
      hb_cnt       <= hb_cnt_d;
      fl_cnt       <= fl_cnt_d;
      rgb_enable   <= en_d;
      rgb_data_out <= data_d;
      line_start   <= ls_d;
      busy         <= (state_d != ST_IDLE);
      frame_done   <= (state_d == ST_DONE);
    end
  end

`ifdef SOBEL_CTRL_STATS_EN
  // Saturating count of upstream starvation cycles while a line is being pulled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
    end else if ((state == ST_IDLE) && start && !abort) begin
      stall_cnt <= 16'h0000;
    end else if ((state == ST_ACTIVE) && !pix.s_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl at IMG_W=4, IMG_H=3, HBLANK=2, FLUSH_CYC=6.
module tb_sobel_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        rgb_enable;
  logic [23:0] rgb_data_out;
  logic        line_start;
  logic        busy;
  logic        frame_done;
  logic [1:0]  row;
  logic [1:0]  col;
`ifdef SOBEL_CTRL_STATS_EN
  logic [15:0] stall_cnt;
`endif

  sobel_frame_ctrl_if pix ();

  sobel_frame_ctrl #(.IMG_W(4), .IMG_H(3), .HBLANK(2), .FLUSH_CYC(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .pix          (pix),
    .rgb_enable   (rgb_enable),
    .rgb_data_out (rgb_data_out),
    .line_start   (line_start),
    .busy         (busy),
    .frame_done   (frame_done),
    .row          (row),
    .col          (col)
`ifdef SOBEL_CTRL_STATS_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, ab, v;
    logic [23:0] d;
    logic        en;
    logic [23:0] od;
    logic        ls, bz, dn;
    logic [1:0]  r, c;
    logic        rdy;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic st, ab, v, input logic [23:0] d,
                     input logic en, input logic [23:0] od, input logic ls, bz, dn,
                     input logic [1:0] r, c, input logic rdy);
    vec_t x;
    x.st = st; x.ab = ab; x.v = v; x.d = d;
    x.en = en; x.od = od; x.ls = ls; x.bz = bz; x.dn = dn;
    x.r = r; x.c = c; x.rdy = rdy;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic en, input logic [23:0] od,
                     input logic ls, bz, dn, input logic [1:0] r, c, input logic rdy);
    logic [32:0] a, e;
    a = {rgb_enable, rgb_data_out, line_start, busy, frame_done, row, col, pix.s_ready};
    e = {en, od, ls, bz, dn, r, c, rdy};
    n_vec++;
    if (a !== e) begin
      n_miss++;
      $display("FAIL %s: got en=%b d=%h ls=%b busy=%b done=%b row=%0d col=%0d rdy=%b, expected en=%b d=%h ls=%b busy=%b done=%b row=%0d col=%0d rdy=%b",
               nm, rgb_enable, rgb_data_out, line_start, busy, frame_done, row, col, pix.s_ready,
               en, od, ls, bz, dn, r, c, rdy);
    end
  endtask

  task automatic chk_val(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic st, ab, v, input logic [23:0] d);
    start = st; abort = ab; pix.s_valid = v; pix.s_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p, t, done_t, act_t, nen, nls, nd, p_done;
    logic rdy_prev;

    // Frame 1: full rate, pixel value = index.
    add(1,0,1, 0, 0, 0,0,1,0, 0,0,1);
    add(0,0,1, 0, 1, 0,1,1,0, 0,1,1);
    add(0,0,1, 1, 1, 1,0,1,0, 0,2,1);
    add(0,0,1, 2, 1, 2,0,1,0, 0,3,1);
    add(0,0,1, 3, 1, 3,0,1,0, 1,0,0);
    add(0,0,1, 4, 0, 0,0,1,0, 1,0,0);
    add(0,0,1, 4, 0, 0,0,1,0, 1,0,1);
    add(0,0,1, 4, 1, 4,1,1,0, 1,1,1);
    add(0,0,1, 5, 1, 5,0,1,0, 1,2,1);
    add(0,0,1, 6, 1, 6,0,1,0, 1,3,1);
    add(0,0,1, 7, 1, 7,0,1,0, 2,0,0);
    add(0,0,1, 8, 0, 0,0,1,0, 2,0,0);
    add(0,0,1, 8, 0, 0,0,1,0, 2,0,1);
    add(0,0,1, 8, 1, 8,1,1,0, 2,1,1);
    add(0,0,1, 9, 1, 9,0,1,0, 2,2,1);
    add(0,0,1,10, 1,10,0,1,0, 2,3,1);
    add(0,0,1,11, 1,11,0,1,0, 2,0,0);
    for (int i = 0; i < 5; i++) add(0,0,1,12, 1,0,0,1,0, 2,0,0);
    add(0,0,1,12, 1, 0,0,1,1, 2,0,0);
    add(0,0,1,12, 0, 0,0,0,0, 2,0,0);
    add(0,0,0, 0, 0, 0,0,0,0, 2,0,0);
    // Frame 2: 3-cycle stall mid-line 1, then abort on flush beat 2.
    add(1,0,1, 0, 0, 0,0,1,0, 0,0,1);
    add(0,0,1, 0, 1, 0,1,1,0, 0,1,1);
    add(0,0,1, 1, 1, 1,0,1,0, 0,2,1);
    add(0,0,1, 2, 1, 2,0,1,0, 0,3,1);
    add(0,0,1, 3, 1, 3,0,1,0, 1,0,0);
    add(0,0,1, 4, 0, 0,0,1,0, 1,0,0);
    add(0,0,1, 4, 0, 0,0,1,0, 1,0,1);
    add(0,0,1, 4, 1, 4,1,1,0, 1,1,1);
    add(0,0,1, 5, 1, 5,0,1,0, 1,2,1);
    for (int i = 0; i < 3; i++) add(0,0,0,5, 0,0,0,1,0, 1,2,1);
    add(0,0,1, 6, 1, 6,0,1,0, 1,3,1);
    add(0,0,1, 7, 1, 7,0,1,0, 2,0,0);
    add(0,0,1, 8, 0, 0,0,1,0, 2,0,0);
    add(0,0,1, 8, 0, 0,0,1,0, 2,0,1);
    add(0,0,1, 8, 1, 8,1,1,0, 2,1,1);
    add(0,0,1, 9, 1, 9,0,1,0, 2,2,1);
    add(0,0,1,10, 1,10,0,1,0, 2,3,1);
    add(0,0,1,11, 1,11,0,1,0, 2,0,0);
    add(0,0,0, 0, 1, 0,0,1,0, 2,0,0);
    add(0,0,0, 0, 1, 0,0,1,0, 2,0,0);
    add(0,1,0, 0, 0, 0,0,0,0, 0,0,0);
    add(0,0,0, 0, 0, 0,0,0,0, 0,0,0);
    add(0,0,0, 0, 0, 0,0,0,0, 0,0,0);
    add(1,1,1, 0, 0, 0,0,0,0, 0,0,0);
    add(0,0,0, 0, 0, 0,0,0,0, 0,0,0);

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pix.s_valid = 1'b0; pix.s_data = 24'h0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_state", 0,0,0,0,0, 0,0,0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      cyc(tbl[i].st, tbl[i].ab, tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d", i), tbl[i].en, tbl[i].od, tbl[i].ls, tbl[i].bz, tbl[i].dn,
          tbl[i].r, tbl[i].c, tbl[i].rdy);
    end

`ifdef SOBEL_CTRL_STATS_EN
    chk_val("stall_cnt", int'(stall_cnt), 3);
`endif

    // Asynchronous reset while row=1, col=2.
    cyc(1,0,1,0);
    for (int i = 0; i < 4; i++) cyc(0,0,1,24'(i));
    cyc(0,0,1,4); cyc(0,0,1,4);
    cyc(0,0,1,4); cyc(0,0,1,5);
    chk("pre_reset_pos", 1,5,0,1,0, 1,2,1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 0,0,0,0,0, 0,0,0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1,0,1,100);
    chk("restart", 0,0,0,1,0, 0,0,1);
    cyc(0,0,1,100);
    chk("restart_px0", 1,100,1,1,0, 0,1,1);
    cyc(0,1,0,0);
    chk("abort_idle", 0,0,0,0,0, 0,0,0);

    // Back-to-back frames with start held high throughout.
    p = 0; done_t = -1; act_t = -1; nen = 0; nls = 0; nd = 0; p_done = -1;
    start = 1'b1; abort = 1'b0; pix.s_valid = 1'b1;
    for (t = 0; t < 200; t++) begin
      pix.s_data = 24'(p);
      rdy_prev = pix.s_ready;
      @(posedge clk); #1;
      if (rdy_prev) p++;
      if (done_t < 0) begin
        if (rgb_enable) nen++;
        if (line_start) nls++;
      end
      if (frame_done) begin
        nd++;
        if (done_t < 0) begin done_t = t; p_done = p; end
      end
      if (done_t >= 0 && t > done_t && pix.s_ready) begin
        act_t = t;
        break;
      end
    end
    if (act_t < 0) begin
      n_vec++; n_miss++;
      $display("FAIL b2b_timeout: got no second frame within 200 cycles, expected restart");
    end else begin
      chk_val("b2b_gap", act_t - done_t, 2);
    end
    chk_val("b2b_enables", nen, 18);
    chk_val("b2b_line_starts", nls, 3);
    chk_val("b2b_done_pulses", nd, 1);
    chk_val("b2b_pixels", p_done, 12);
    cyc(0,1,0,0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
